sprite_dispatcher: RTL and testbench

SPRITE_DISPATCHER -- requirements
Module: sprite_dispatcher

---
 rtl/sprite_dispatcher.sv | 131 +++++++++++++
 tb/tb_sprite_dispatcher.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_dispatcher.sv
// Sprite dispatcher: accepts one sprite descriptor, fetches its 64-word texture tile
// from word-addressed memory, then broadcasts the assembled tile with a one-cycle strobe.
module sprite_dispatcher #(
    parameter int TEX_WORDS = 64,
    parameter int ADDR_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [3:0]             s_start_x,
    input  logic [7:0]             s_position_z,
    input  logic [ADDR_W-1:0]      s_tex_addr,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ready,
    input  logic                   mem_rd_valid,
    input  logic [31:0]            mem_rd_data,
    output logic                   o_ena,
    output logic [32*TEX_WORDS-1:0] o_texture_data,
    output logic [3:0]             o_start_x,
    output logic [7:0]             o_position_z,
    output logic                   o_busy
);

    localparam int                CNT_W   = $clog2(TEX_WORDS + 1);
    localparam logic [CNT_W-1:0]  WORDS_C = CNT_W'(TEX_WORDS);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(TEX_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  issue_cnt_reg, issue_cnt_next;
    logic [CNT_W-1:0]  ret_cnt_reg, ret_cnt_next;
    logic [ADDR_W-1:0] tex_addr_reg;
    logic [3:0]        start_x_reg;
    logic [7:0]        pos_z_reg;

    logic accept;
    logic issue;
    logic capture;
    logic last_capture;

    assign accept       = s_valid && (state_reg == IDLE);
    assign mem_rd_en    = (state_reg == FETCH) && (issue_cnt_reg < WORDS_C);
    assign mem_addr     = tex_addr_reg + ADDR_W'(issue_cnt_reg);
    assign issue        = mem_rd_en && mem_ready;
    // Returns outside FETCH or past the last word are dropped without effect.
    assign capture      = (state_reg == FETCH) && mem_rd_valid && (ret_cnt_reg < WORDS_C);
    assign last_capture = capture && (ret_cnt_reg == LAST_C);

    assign s_ready = (state_reg == IDLE);
    assign o_busy  = (state_reg != IDLE);
    assign o_ena   = (state_reg == EMIT);

    always_comb begin
        state_next     = state_reg;
        issue_cnt_next = issue_cnt_reg;
        ret_cnt_next   = ret_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next     = FETCH;
                    issue_cnt_next = '0;
                    ret_cnt_next   = '0;
                end
            end
            FETCH: begin
                if (issue) begin
                    issue_cnt_next = issue_cnt_reg + 1'b1;
                end
                if (capture) begin
                    ret_cnt_next = ret_cnt_reg + 1'b1;
                end
                if (last_capture) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            tex_addr_reg  <= '0;
            start_x_reg   <= '0;
            pos_z_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            issue_cnt_reg <= issue_cnt_next;
            ret_cnt_reg   <= ret_cnt_next;
            if (accept) begin
                tex_addr_reg <= s_tex_addr;
                start_x_reg  <= s_start_x;
                pos_z_reg    <= s_position_z;
            end
        end
    end

    // Broadcast outputs keep the previous sprite until the first word of the next one lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_texture_data <= '0;
            o_start_x      <= '0;
            o_position_z   <= '0;
        end else if (capture) begin
            for (int i = 0; i < TEX_WORDS; i++) begin
                if (ret_cnt_reg == CNT_W'(i)) begin
                    o_texture_data[32*i +: 32] <= mem_rd_data;
                end
            end
            if (ret_cnt_reg == '0) begin
                o_start_x    <= start_x_reg;
                o_position_z <= pos_z_reg;
            end
        end
    end

endmodule

// File: tb/tb_sprite_dispatcher.sv
// Directed bench for sprite_dispatcher: memory responder, expected-address/tile
// scoreboard checked every cycle, and a depth-compositing stream-array model.
module tb_sprite_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          s_valid;
    logic          s_ready;
    logic [3:0]    s_start_x;
    logic [7:0]    s_position_z;
    logic [15:0]   s_tex_addr;
    logic          mem_rd_en;
    logic [15:0]   mem_addr;
    logic          mem_ready;
    logic          mem_rd_valid;
    logic [31:0]   mem_rd_data;
    logic          o_ena;
    logic [2047:0] o_texture_data;
    logic [3:0]    o_start_x;
    logic [7:0]    o_position_z;
    logic          o_busy;

    sprite_dispatcher #(.TEX_WORDS(64), .ADDR_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_start_x      (s_start_x),
        .s_position_z   (s_position_z),
        .s_tex_addr     (s_tex_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .o_ena          (o_ena),
        .o_texture_data (o_texture_data),
        .o_start_x      (o_start_x),
        .o_position_z   (o_position_z),
        .o_busy         (o_busy)
    );

    // ---------------- memory responder ----------------
    logic [31:0] mem [0:65535];
    int          lat = 0;
    logic        toggle_mode = 1'b0;
    logic        rdy_phase = 1'b0;
    logic        spurious = 1'b0;
    logic        pv [0:7] = '{default: 1'b0};
    logic [31:0] pv_data [0:7] = '{default: 32'h0};

    always_comb begin
        mem_ready = toggle_mode ? rdy_phase : 1'b1;
        if (lat == 0) begin
            mem_rd_valid = mem_rd_en && mem_ready;
            mem_rd_data  = mem[mem_addr];
        end else begin
            mem_rd_valid = pv[lat-1];
            mem_rd_data  = pv_data[lat-1];
        end
        if (spurious) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hDEADBEEF;
        end
    end

    int cyc = 0;
    int last_acc = 0;
    int accepts = 0;
    int rets = 0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rdy_phase <= ~rdy_phase;
        pv[0]      <= mem_rd_en && mem_ready;
        pv_data[0] <= mem[mem_addr];
        for (int i = 1; i < 8; i++) begin
            pv[i]      <= pv[i-1];
            pv_data[i] <= pv_data[i-1];
        end
        if (reset_n && s_valid && s_ready) begin
            last_acc <= cyc;
            accepts  <= accepts + 1;
        end
        if (reset_n && mem_rd_valid && o_busy) rets <= rets + 1;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2047:0] tile;
        logic [3:0]    x;
        logic [7:0]    z;
    } emit_t;

    emit_t       exp_emit_q[$];
    logic [15:0] exp_addr_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_tile(input string name, input logic [2047:0] act, input logic [2047:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            for (int i = 0; i < 64; i++) begin
                if (act[32*i +: 32] !== exp[32*i +: 32]) begin
                    $display("FAIL %s: word %0d got %08h expected %08h (cycle %0d)",
                             name, i, act[32*i +: 32], exp[32*i +: 32], cyc);
                    break;
                end
            end
        end
    endtask

    // Stream-processor array model: 16 rows x 32 columns, larger depth wins, 0xFF transparent.
    logic [7:0] fb [0:15][0:31];
    logic [7:0] fz [0:15][0:31];

    int    pulses = 0;
    int    last_lat = 0;
    int    ena_cyc = 0;
    int    ena_gap = 0;
    logic  prev_ena = 1'b0;
    logic  prev_stall = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    emit_t e;

    always @(negedge clk) begin
        if (reset_n) begin
            chk("ready_vs_busy", s_ready, !o_busy);
            if (mem_rd_en && prev_stall) chk("addr_hold", mem_addr, prev_addr);
            if (mem_rd_en && mem_ready) begin
                if (exp_addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_request: addr %04h with none expected", mem_addr);
                end else begin
                    chk("mem_addr", mem_addr, exp_addr_q.pop_front());
                end
            end
            prev_stall = mem_rd_en && !mem_ready;
            prev_addr  = mem_addr;
            if (o_ena) begin
                pulses++;
                last_lat = cyc - last_acc;
                ena_gap  = cyc - ena_cyc;
                ena_cyc  = cyc;
                chk("ena_single", prev_ena, 1'b0);
                chk("ena_busy", o_busy, 1'b1);
                if (exp_emit_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_ena: o_ena with no sprite expected");
                end else begin
                    e = exp_emit_q.pop_front();
                    chk_tile("tile", o_texture_data, e.tile);
                    chk("emit_x", o_start_x, e.x);
                    chk("emit_z", o_position_z, e.z);
                end
                for (int j = 0; j < 256; j++) begin
                    int r, c;
                    logic [7:0] b;
                    r = j / 16;
                    c = int'(o_start_x) + (j % 16);
                    b = o_texture_data[8*j +: 8];
                    if (b != 8'hFF && o_position_z >= fz[r][c]) begin
                        fb[r][c] = b;
                        fz[r][c] = o_position_z;
                    end
                end
            end
            prev_ena = o_ena;
        end else begin
            prev_ena   = 1'b0;
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input logic [3:0] x, input logic [7:0] z, input logic [15:0] addr);
        emit_t n;
        for (int k = 0; k < 64; k++) begin
            exp_addr_q.push_back(addr + 16'(k));
            n.tile[32*k +: 32] = mem[addr + 16'(k)];
        end
        n.x = x;
        n.z = z;
        exp_emit_q.push_back(n);
    endtask

    task automatic send(input logic [3:0] x, input logic [7:0] z, input logic [15:0] addr, input bit keep);
        int a;
        push_exp(x, z, addr);
        s_start_x    = x;
        s_position_z = z;
        s_tex_addr   = addr;
        s_valid      = 1'b1;
        a = accepts;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (accepts > a) break;
        end
        if (accepts == a) begin
            tests++; fails++;
            $display("FAIL accept_timeout: descriptor z=%02h never accepted", z);
        end
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic wait_ena(input int max_cyc);
        int target;
        target = pulses + 1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (pulses >= target) return;
        end
        tests++; fails++;
        $display("FAIL ena_timeout: no o_ena within %0d cycles", max_cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [2047:0] tile1;
        int p0, a2, r0;
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_start_x = '0;
        s_position_z = '0;
        s_tex_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_ena", o_ena, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ready", s_ready, 1'b1);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_x", o_start_x, 4'h0);
        chk("rst_z", o_position_z, 8'h0);
        chk_tile("rst_tile", o_texture_data, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic tile: byte j must equal j.
        for (int k = 0; k < 64; k++) mem[16'h0100 + 16'(k)] = 32'h03020100 + 32'h04040404 * k;
        send(4'd3, 8'h40, 16'h0100, 1'b0);
        wait_ena(200);
        chk("t1_latency", last_lat, 65);
        chk("t1_byte0", o_texture_data[7:0], 8'h00);
        chk("t1_byte5", o_texture_data[47:40], 8'h05);
        chk("t1_byte100", o_texture_data[807:800], 8'd100);
        chk("t1_byte255", o_texture_data[2047:2040], 8'hFF);
        chk("t1_x", o_start_x, 4'd3);
        chk("t1_z", o_position_z, 8'h40);
        repeat (3) @(negedge clk);

        // Address wrap at the top of memory.
        for (int k = 0; k < 64; k++) mem[16'hFFF0 + 16'(k)] = 32'hA5000000 | k;
        send(4'd5, 8'h80, 16'hFFF0, 1'b0);
        wait_ena(200);
        chk("t2_latency", last_lat, 65);
        chk("t2_word0", o_texture_data[31:0], 32'hA5000000);
        chk("t2_word16", o_texture_data[32*16 +: 32], 32'hA5000010);
        chk("t2_word63", o_texture_data[32*63 +: 32], 32'hA500003F);
        chk("t2_addrs_left", exp_addr_q.size(), 0);
        repeat (3) @(negedge clk);

        // Backpressure every other cycle plus 3-cycle return latency.
        lat = 3;
        toggle_mode = 1'b1;
        for (int k = 0; k < 64; k++) mem[16'h4000 + 16'(k)] = $urandom;
        p0 = pulses;
        send(4'd7, 8'h33, 16'h4000, 1'b0);
        wait_ena(400);
        repeat (20) @(negedge clk);
        chk("t3_pulses", pulses, p0 + 1);
        chk("t3_addrs_left", exp_addr_q.size(), 0);
        lat = 0;
        toggle_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Two queued descriptors with s_valid held high.
        for (int k = 0; k < 64; k++) begin
            mem[16'h0500 + 16'(k)] = $urandom;
            mem[16'h0600 + 16'(k)] = $urandom;
        end
        send(4'd1, 8'h21, 16'h0500, 1'b1);
        push_exp(4'd2, 8'h42, 16'h0600);
        s_start_x    = 4'd2;
        s_position_z = 8'h42;
        s_tex_addr   = 16'h0600;
        a2 = accepts;
        wait_ena(200);
        tile1 = o_texture_data;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (accepts > a2) s_valid = 1'b0;
            chk_tile("t4_hold_tile", o_texture_data, tile1);
            chk("t4_hold_x", o_start_x, 4'd1);
            if (mem_rd_valid) break;
        end
        chk("t4_hold_reached", mem_rd_valid, 1'b1);
        wait_ena(200);
        s_valid = 1'b0;
        chk("t4_ena_gap", ena_gap, 66);
        chk("t4_x2", o_start_x, 4'd2);
        repeat (3) @(negedge clk);

        // Reset in the middle of a fetch, then stale and spurious returns.
        lat = 2;
        for (int k = 0; k < 64; k++) mem[16'h0700 + 16'(k)] = $urandom | 32'h1;
        r0 = rets;
        p0 = pulses;
        send(4'd9, 8'h55, 16'h0700, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (rets >= r0 + 20) break;
            @(negedge clk);
        end
        chk("t5_reached_20", rets >= r0 + 20, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", o_busy, 1'b0);
        chk("t5_rst_rd_en", mem_rd_en, 1'b0);
        chk("t5_rst_x", o_start_x, 4'h0);
        chk("t5_rst_z", o_position_z, 8'h0);
        chk_tile("t5_rst_tile", o_texture_data, '0);
        exp_addr_q.delete();
        exp_emit_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        spurious = 1'b0;
        repeat (80) @(negedge clk);
        chk("t5_no_ena", pulses, p0);
        chk("t5_busy", o_busy, 1'b0);
        chk("t5_ready", s_ready, 1'b1);
        chk("t5_x", o_start_x, 4'h0);
        chk("t5_z", o_position_z, 8'h0);
        chk_tile("t5_tile", o_texture_data, '0);
        lat = 0;
        repeat (3) @(negedge clk);

        // Overlapping sprites into the stream-array model.
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 32; c++) begin
                fb[r][c] = 8'h00;
                fz[r][c] = 8'h00;
            end
        end
        for (int k = 0; k < 64; k++) mem[16'h0200 + 16'(k)] = 32'h11111111;
        for (int j = 0; j < 256; j++) begin
            mem[16'h0300 + 16'(j / 4)][8*(j % 4) +: 8] = ((j % 16) == 1) ? 8'hFF : 8'h22;
        end
        send(4'd0, 8'h10, 16'h0200, 1'b0);
        wait_ena(200);
        send(4'd8, 8'h20, 16'h0300, 1'b0);
        wait_ena(200);
        chk("t6_overlap_c8", fb[0][8], 8'h22);
        chk("t6_transp_c9", fb[0][9], 8'h11);
        chk("t6_transp_r7c9", fb[7][9], 8'h11);
        chk("t6_a_only_c7", fb[0][7], 8'h11);
        chk("t6_overlap_r2c15", fb[2][15], 8'h22);
        chk("t6_b_only_r5c17", fb[5][17], 8'h22);
        chk("t6_b_edge_r15c23", fb[15][23], 8'h22);
        chk("t6_empty_r4c24", fb[4][24], 8'h00);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
